persp_div: RTL

- Perspective-divide stage directly downstream of the reciprocal unit in the vertex path.
- Accepts one clip-space vertex (x, y, z signed; w unsigned) per handshake.
- Obtains 1/w from an internal rcp instance, then scales x, y and z by it using one shared multiplier over three cycles.
- Presents the normalised vertex to the rasteriser setup through a valid/ready handshake.

---
 rtl/persp_div.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/persp_div.sv
// persp_div: perspective-divide stage for the vertex path.
//
// Accepts one clip-space vertex (signed x, y, z; unsigned w) per input
// handshake, obtains 1/w from the rcp unit, then scales x, y and z by the
// reciprocal through a single shared multiplier (one coordinate per cycle).
// w == 1 passes the coordinates through unchanged; w == 0 yields zeros with
// div0_o raised.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_v_i / in_ready_o     input vertex handshake (ready only when idle)
//   x_i, y_i, z_i           signed input coordinates
//   w_i                     unsigned homogeneous w
//   out_v_o / out_ready_i   output vertex handshake
//   x_o, y_o, z_o           signed divided coordinates
//   div0_o                  output vertex came from w == 0 (valid with out_v_o)
//
// rcp: registered fixed-point reciprocal, r_o = floor(2^width / a_i) for
// a_i >= 2, one cycle after a v_i pulse (ready_o pulses with the result).
//   clk_i, rst_i   clock, asynchronous active-high reset
//   v_i, a_i       request strobe and divisor
//   ready_o, r_o   result strobe and reciprocal

module rcp #(
  parameter int unsigned width = 16,
  parameter int unsigned iters = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             v_i,
  input  logic [width-1:0] a_i,
  output logic             ready_o,
  output logic [width-1:0] r_o
);

  // Working precision: F fraction bits, PW bits wide enough for every product.
  localparam int unsigned F  = 2 * width;
  localparam int unsigned PW = 2 * F + 4;
  localparam logic [PW-1:0] ONE_PW = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_F  = ONE_PW << F;
  localparam logic [PW-1:0] TWO_F  = ONE_F << 1;
  localparam logic [PW-1:0] ONE_W  = ONE_PW << width;
  // Linear seed 48/17 - 32/17*d for 1/d on [0.5, 1): relative error <= 1/17.
  localparam logic [PW-1:0] C1 = (ONE_F * PW'(48)) / PW'(17);
  localparam logic [PW-1:0] C2 = (ONE_F * PW'(32)) / PW'(17);

  logic               ready_q;
  logic [width-1:0]   r_q;
  logic [width-1:0]   r_d;
  logic [PW-1:0]      a_x;
  logic [PW-1:0]      d;
  logic [PW-1:0]      y;
  logic [PW-1:0]      t;
  logic [PW-1:0]      q;
  logic signed [PW-1:0] rem;
  int unsigned        p;
  logic               unused_q;

  always_comb begin
    // Normalise a into d = a / 2^(p+1) in [0.5, 1), scaled by 2^F.
    p = '0;
    for (int unsigned i = 0; i < width; i++) begin
      if (a_i[i]) p = i;
    end
    a_x = PW'(a_i);
    d   = a_x << (F - 1 - p);
    y   = C1 - ((C2 * d) >> F);
    t   = '0;
    // Newton-Raphson: y <- y * (2 - d*y); error squares each pass.
    for (int unsigned k = 0; k < iters; k++) begin
      t = (d * y) >> F;
      y = (y * (TWO_F - t)) >> F;
    end
    // Denormalise, then nudge the quotient to the exact floor using the
    // remainder; truncation in the iterations leaves it within +-1.
    q   = y >> (F + 1 + p - width);
    rem = $signed(ONE_W - q * a_x);
    for (int unsigned k = 0; k < 2; k++) begin
      if (rem[PW-1]) begin
        q   = q - ONE_PW;
        rem = rem + $signed(a_x);
      end
    end
    for (int unsigned k = 0; k < 2; k++) begin
      if (!rem[PW-1] && (rem >= $signed(a_x))) begin
        q   = q + ONE_PW;
        rem = rem - $signed(a_x);
      end
    end
    r_d      = q[width-1:0];
    unused_q = ^q[PW-1:width];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      r_q     <= '0;
    end else begin
      ready_q <= v_i;
      if (v_i) r_q <= r_d;
    end
  end

  assign ready_o = ready_q;
  assign r_o     = r_q;

endmodule

module persp_div #(
  parameter int unsigned width = 16,
  parameter int unsigned iters = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_v_i,
  output logic                    in_ready_o,
  input  logic signed [width-1:0] x_i,
  input  logic signed [width-1:0] y_i,
  input  logic signed [width-1:0] z_i,
  input  logic        [width-1:0] w_i,
  output logic                    out_v_o,
  input  logic                    out_ready_i,
  output logic signed [width-1:0] x_o,
  output logic signed [width-1:0] y_o,
  output logic signed [width-1:0] z_o,
  output logic                    div0_o
);

  typedef enum logic [2:0] {IDLE, RCP, MUL_X, MUL_Y, MUL_Z, BYP, OUT} state_t;

  state_t state_q, state_d;
  logic signed [width-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic        [width-1:0] w_q, w_d;
  logic        [width-1:0] recip_q, recip_d;
  logic signed [width-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic                    div0_q, div0_d;
  // RCP: request already issued. BYP: first of its two cycles done.
  logic                    phase_q, phase_d;

  logic                    rcp_v;
  logic                    rcp_ready;
  logic        [width-1:0] rcp_r;

  logic signed [width-1:0]   mul_c;
  logic signed [2*width:0]   mul_a;
  logic signed [2*width:0]   mul_b;
  logic signed [2*width:0]   mul_p;
  logic signed [2*width:0]   mul_sh;
  logic signed [width-1:0]   mul_res;
  logic                      unused_mul;

  rcp #(
    .width(width),
    .iters(iters)
  ) u_rcp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .v_i    (rcp_v),
    .a_i    (w_q),
    .ready_o(rcp_ready),
    .r_o    (rcp_r)
  );

  // Shared multiplier: recip is zero-extended so it stays non-negative;
  // >>> floors toward negative infinity.
  always_comb begin
    case (state_q)
      MUL_Y:   mul_c = y_q;
      MUL_Z:   mul_c = z_q;
      default: mul_c = x_q;
    endcase
    mul_a      = {{(width+1){mul_c[width-1]}}, mul_c};
    mul_b      = {{(width+1){1'b0}}, recip_q};
    mul_p      = mul_a * mul_b;
    mul_sh     = mul_p >>> width;
    mul_res    = mul_sh[width-1:0];
    unused_mul = ^mul_sh[2*width:width];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    w_d     = w_q;
    recip_d = recip_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    div0_d  = div0_q;
    phase_d = phase_q;
    rcp_v   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_v_i) begin
          x_d     = x_i;
          y_d     = y_i;
          z_d     = z_i;
          w_d     = w_i;
          state_d = (|w_i[width-1:1]) ? RCP : BYP;
        end
      end
      RCP: begin
        // Single request, then wait on ready_o whatever the rcp depth.
        rcp_v   = !phase_q;
        phase_d = 1'b1;
        if (rcp_ready) begin
          recip_d = rcp_r;
          phase_d = 1'b0;
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        xo_d    = mul_res;
        state_d = MUL_Y;
      end
      MUL_Y: begin
        yo_d    = mul_res;
        state_d = MUL_Z;
      end
      MUL_Z: begin
        zo_d    = mul_res;
        div0_d  = 1'b0;
        state_d = OUT;
      end
      BYP: begin
        // Two cycles: the result appears two edges after acceptance.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = OUT;
          if (w_q == '0) begin
            xo_d   = '0;
            yo_d   = '0;
            zo_d   = '0;
            div0_d = 1'b1;
          end else begin
            xo_d   = x_q;
            yo_d   = y_q;
            zo_d   = z_q;
            div0_d = 1'b0;
          end
        end
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      w_q     <= '0;
      recip_q <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      div0_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      w_q     <= w_d;
      recip_q <= recip_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      div0_q  <= div0_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready_o = (state_q == IDLE);
  assign out_v_o    = (state_q == OUT);
  assign x_o        = xo_q;
  assign y_o        = yo_q;
  assign z_o        = zo_q;
  assign div0_o     = div0_q;

endmodule
